// File: rtl/axi_stream_skid.sv
// Two-entry registered FIFO used as a skid buffer in front of the join.
// Ready and valid come only from registered occupancy, never from the far side.
module axi_stream_skid #(
  parameter int DATA_WD = 4
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               i_in_valid,
  input  logic [DATA_WD-1:0] i_in_data,
  output logic               o_in_ready,
  output logic               o_out_valid,
  output logic [DATA_WD-1:0] o_out_data,
  input  logic               i_out_ready
);
  localparam int DEPTH = 2;

  logic [DATA_WD-1:0] r_mem [DEPTH];
  logic               r_wr_ptr;
  logic               r_rd_ptr;
  logic [1:0]         r_count;
  logic               w_push;
  logic               w_pop;

  assign o_in_ready  = (r_count != 2'(DEPTH));
  assign o_out_valid = (r_count != 2'd0);
  assign o_out_data  = r_mem[r_rd_ptr];
  assign w_push      = i_in_valid && o_in_ready;
  assign w_pop       = i_out_ready && o_out_valid;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_mem[0] <= '0;
      r_mem[1] <= '0;
      r_wr_ptr <= 1'b0;
      r_rd_ptr <= 1'b0;
      r_count  <= 2'd0;
    end else begin
      if (w_push) begin
        r_mem[r_wr_ptr] <= i_in_data;
        r_wr_ptr        <= ~r_wr_ptr;
      end
      if (w_pop) begin
        r_rd_ptr <= ~r_rd_ptr;
      end
      // push and pop together leave occupancy unchanged
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + 2'd1;
        2'b01:   r_count <= r_count - 2'd1;
        default: r_count <= r_count;
      endcase
    end
  end
endmodule

// File: rtl/axi_stream_join.sv
// Two-to-one stream join: pairs the k-th b beat with the k-th c beat and emits
// {b, c} from a registered output stage; skids isolate input ready from a_ready.
module axi_stream_join #(
  parameter int DATA_WD = 4
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 b_valid,
  input  logic [DATA_WD-1:0]   b_data,
  output logic                 b_ready,
  input  logic                 c_valid,
  input  logic [DATA_WD-1:0]   c_data,
  output logic                 c_ready,
  output logic                 a_valid,
  output logic [2*DATA_WD-1:0] a_data,
  input  logic                 a_ready
);
  logic               w_b_head_valid;
  logic [DATA_WD-1:0] w_b_head_data;
  logic               w_c_head_valid;
  logic [DATA_WD-1:0] w_c_head_data;
  logic               w_join;

  logic                 r_a_valid;
  logic [2*DATA_WD-1:0] r_a_data;

  axi_stream_skid #(.DATA_WD(DATA_WD)) u_skid_b (
    .clk         (clk),
    .rst_n       (rst_n),
    .i_in_valid  (b_valid),
    .i_in_data   (b_data),
    .o_in_ready  (b_ready),
    .o_out_valid (w_b_head_valid),
    .o_out_data  (w_b_head_data),
    .i_out_ready (w_join)
  );

  axi_stream_skid #(.DATA_WD(DATA_WD)) u_skid_c (
    .clk         (clk),
    .rst_n       (rst_n),
    .i_in_valid  (c_valid),
    .i_in_data   (c_data),
    .o_in_ready  (c_ready),
    .o_out_valid (w_c_head_valid),
    .o_out_data  (w_c_head_data),
    .i_out_ready (w_join)
  );

  // both heads present and the output slot is empty or being drained this edge
  assign w_join = w_b_head_valid && w_c_head_valid && (!r_a_valid || a_ready);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_a_valid <= 1'b0;
      r_a_data  <= '0;
    end else if (w_join) begin
      r_a_valid <= 1'b1;
      r_a_data  <= {w_b_head_data, w_c_head_data};
    end else if (a_ready) begin
      r_a_valid <= 1'b0;
    end
  end

  assign a_valid = r_a_valid;
  assign a_data  = r_a_data;
endmodule

// File: tb/tb_axi_stream_join.sv
// Directed and random bench for axi_stream_join with an in-order pairing scoreboard.
module tb_axi_stream_join;
  logic       clk = 1'b0;
  logic       rst_n;
  logic       b_valid, c_valid, a_ready;
  logic [3:0] b_data, c_data;
  logic       b_ready, c_ready, a_valid;
  logic [7:0] a_data;

  axi_stream_join #(.DATA_WD(4)) dut (
    .clk(clk), .rst_n(rst_n),
    .b_valid(b_valid), .b_data(b_data), .b_ready(b_ready),
    .c_valid(c_valid), .c_data(c_data), .c_ready(c_ready),
    .a_valid(a_valid), .a_data(a_data), .a_ready(a_ready)
  );

  always #5 clk = ~clk;

  int n_pass = 0;
  int n_total = 0;
  int n_abeats = 0;
  int nb = 0;
  int nc = 0;
  logic b_fire = 1'b0;
  logic c_fire = 1'b0;
  logic [3:0] qb[$];
  logic [3:0] qc[$];
  logic [7:0] qexp[$];
  logic [3:0] bsk[3] = '{4'h1, 4'h2, 4'h3};
  logic [3:0] csk[3] = '{4'hE, 4'hF, 4'hD};

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_total++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // record this cycle's handshakes, check the output beat, then advance one edge
  task automatic cycle();
    logic [3:0] hb, hc;
    b_fire = b_valid && b_ready;
    c_fire = c_valid && c_ready;
    if (b_fire) begin qb.push_back(b_data); nb++; end
    if (c_fire) begin qc.push_back(c_data); nc++; end
    if (a_valid) begin
      if (qexp.size() == 0) chk("a_spurious", a_valid, 1'b0);
      else begin
        chk("a_data", a_data, qexp[0]);
        if (a_ready) begin void'(qexp.pop_front()); n_abeats++; end
      end
    end
    while (qb.size() > 0 && qc.size() > 0) begin
      hb = qb.pop_front();
      hc = qc.pop_front();
      qexp.push_back({hb, hc});
    end
    tick();
  endtask

  task automatic latency_check(input string tag, input logic [3:0] bv, input logic [3:0] cv,
                               input logic [7:0] exp);
    a_ready = 1'b1;
    b_valid = 1'b1; b_data = bv;
    c_valid = 1'b1; c_data = cv;
    chk({tag, "_ready"}, {b_ready, c_ready}, 2'b11);
    cycle();
    b_valid = 1'b0; c_valid = 1'b0;
    chk({tag, "_c1_valid"}, a_valid, 1'b0);
    cycle();
    chk({tag, "_c2_valid"}, a_valid, 1'b1);
    chk({tag, "_c2_data"}, a_data, exp);
    cycle();
    for (int k = 0; k < 3; k++) begin
      chk({tag, "_idle_valid"}, a_valid, 1'b0);
      cycle();
    end
  endtask

  task automatic reset_model();
    qb.delete(); qc.delete(); qexp.delete();
    b_fire = 1'b0; c_fire = 1'b0;
  endtask

  initial begin
    int base, first, last, cnt, cyc;
    rst_n = 1'b0;
    b_valid = 1'b0; c_valid = 1'b0; a_ready = 1'b0;
    b_data = '0; c_data = '0;
    repeat (3) @(posedge clk);
    #3 rst_n = 1'b1;
    tick();
    chk("rst_a_valid", a_valid, 1'b0);
    chk("rst_a_data", a_data, 8'h00);
    chk("rst_b_ready", b_ready, 1'b1);
    chk("rst_c_ready", c_ready, 1'b1);

    latency_check("lat", 4'h3, 4'hA, 8'h3A);

    // streaming: b=1..8, c=8..1 -> 0x18..0x81 on consecutive cycles
    a_ready = 1'b1; first = -1; last = -1; cnt = 0;
    for (int k = 0; k < 12; k++) begin
      b_valid = (k < 8); b_data = 4'(k + 1);
      c_valid = (k < 8); c_data = 4'(8 - k);
      if (a_valid) begin
        cnt++;
        if (first < 0) first = k;
        last = k;
      end
      cycle();
    end
    chk("stream_beats", cnt, 8);
    chk("stream_first", first, 2);
    chk("stream_last", last, 9);

    // skew: b runs ahead by two, then c catches up
    b_valid = 1'b0; c_valid = 1'b0; a_ready = 1'b1;
    nb = 0; nc = 0; base = n_abeats;
    for (int k = 0; k < 4; k++) begin
      b_valid = (nb < 3); b_data = (nb < 3) ? bsk[nb] : 4'h0;
      cycle();
    end
    chk("skew_b_count", nb, 2);
    chk("skew_b_ready", b_ready, 1'b0);
    for (int k = 0; k < 12; k++) begin
      b_valid = (nb < 3); b_data = (nb < 3) ? bsk[nb] : 4'h0;
      c_valid = (nc < 3); c_data = (nc < 3) ? csk[nc] : 4'h0;
      cycle();
    end
    chk("skew_beats", n_abeats - base, 3);
    chk("skew_c_count", nc, 3);

    // backpressure: three beats per input accepted while a_ready is low
    a_ready = 1'b0; nb = 0; nc = 0;
    for (int k = 0; k < 8; k++) begin
      b_valid = 1'b1; b_data = 4'(5 + nb);
      c_valid = 1'b1; c_data = 4'(9 + nc);
      cycle();
    end
    chk("bp_b_accepted", nb, 3);
    chk("bp_c_accepted", nc, 3);
    chk("bp_b_ready", b_ready, 1'b0);
    chk("bp_c_ready", c_ready, 1'b0);
    chk("bp_a_valid", a_valid, 1'b1);
    chk("bp_a_data", a_data, 8'h59);
    b_valid = 1'b0; c_valid = 1'b0; a_ready = 1'b1; base = n_abeats;
    for (int k = 0; k < 6; k++) cycle();
    chk("bp_drain_beats", n_abeats - base, 3);
    chk("bp_drain_empty", qexp.size(), 0);

    // random valid/ready on all ports
    base = n_abeats; cyc = 0; b_fire = 1'b0; c_fire = 1'b0;
    while (n_abeats - base < 10000 && cyc < 40000) begin
      if (!b_valid || b_fire) begin
        b_valid = ($urandom_range(0, 3) != 0); b_data = 4'($urandom_range(0, 15));
      end
      if (!c_valid || c_fire) begin
        c_valid = ($urandom_range(0, 3) != 0); c_data = 4'($urandom_range(0, 15));
      end
      a_ready = ($urandom_range(0, 3) != 0);
      cycle();
      cyc++;
    end
    chk("rand_beats_reached", (n_abeats - base) >= 10000, 1'b1);
    cyc = 0;
    while ((qb.size() > 0 || qc.size() > 0) && cyc < 100) begin
      b_valid = (qc.size() > 0); b_data = 4'($urandom_range(0, 15));
      c_valid = (qb.size() > 0); c_data = 4'($urandom_range(0, 15));
      a_ready = 1'b1;
      cycle();
      cyc++;
    end
    b_valid = 1'b0; c_valid = 1'b0; a_ready = 1'b1;
    for (int k = 0; k < 6; k++) cycle();
    chk("rand_drain_empty", qexp.size() + qb.size() + qc.size(), 0);

    // asynchronous reset with beats buffered
    a_ready = 1'b0;
    b_valid = 1'b1; b_data = 4'h7;
    c_valid = 1'b1; c_data = 4'h4;
    cycle();
    cycle();
    chk("pre_rst_a_valid", a_valid, 1'b1);
    b_valid = 1'b0; c_valid = 1'b0;
    #2 rst_n = 1'b0;
    #1;
    chk("arst_a_valid", a_valid, 1'b0);
    chk("arst_a_data", a_data, 8'h00);
    chk("arst_b_ready", b_ready, 1'b1);
    chk("arst_c_ready", c_ready, 1'b1);
    reset_model();
    #1 rst_n = 1'b1;
    tick();
    chk("post_rst_a_valid", a_valid, 1'b0);
    latency_check("post_rst", 4'h6, 4'h5, 8'h65);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

  initial begin
    #700000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end
endmodule
